regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the CPU datapath; successor to the 2R/1W file.
//  Provides NUM_RD registered read ports, two write ports and same-cycle write-to-read bypass.
//  Hardwires register 0 to zero and adds a per-register busy scoreboard for hazard detection.
//  Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).
// PARAMETERS
//  DATA_W  32  data width in bits
//  ADDR_W  5   address width; depth = 2**ADDR_W registers
//  NUM_RD  2   number of read ports, 1..4
// PORTS
//  clk         in   1              clock; all state updates on posedge
//  rst         in   1              synchronous, active-high reset
//  rd_addr     in   NUM_RD*ADDR_W  read addresses; port i = [i*ADDR_W +: ADDR_W]
//  rd_data     out  NUM_RD*DATA_W  registered read data; port i = [i*DATA_W +: DATA_W]
//  rd_busy     out  NUM_RD         registered scoreboard bit for each rd_addr
//  wr_en       in   2              per-port write enable
//  wr_addr     in   2*ADDR_W       write addresses, port j = [j*ADDR_W +: ADDR_W]
//  wr_data     in   2*DATA_W       write data, port j = [j*DATA_W +: DATA_W]
//  sb_set_en   in   1              mark sb_set_addr busy (instruction issued)
//  sb_set_addr in   ADDR_W         destination register being issued
// BEHAVIOUR
//  - Reset, rst=1 at posedge: all registers = 0, scoreboard = 0, rd_data = 0, rd_busy = 0.
//    rst overrides all writes and sets in the same cycle. Mid-operation reset loses pending writes.
//  - Write: at posedge, if wr_en[j] and wr_addr[j]!=0, then reg[wr_addr[j]] <= wr_data[j].
//    Writes to address 0 are discarded.
//  - Write collision: both ports enabled to the same address -> port 1 wins; port 0 is dropped.
//  - Read latency: 1 cycle. rd_addr sampled at posedge N; rd_data valid after posedge N and held until the next posedge.
//  - Read value at posedge N, for port i with address a:
//      a==0                    -> 0
//      wr_en[1] & wr_addr[1]==a -> wr_data[1]   (bypass, port 1 has priority)
//      wr_en[0] & wr_addr[0]==a -> wr_data[0]   (bypass)
//      otherwise               -> reg[a], the value before this edge
//  - Read ports are fully independent; any number of them may use the same address.
//  - Scoreboard: one busy bit per register; bit 0 is constant 0.
//    Set when sb_set_en and sb_set_addr!=0. Cleared when any write port writes that address.
//    Set and clear on the same address in the same cycle -> set wins, because the new producer is younger.
//  - rd_busy[i] is registered with rd_data. It reflects the scoreboard after this edge's set/clear,
//    so a bypassed write reads busy=0 unless a set to the same address occurs in the same cycle.
//  - All arithmetic is address compare only; no wrap or overflow concerns. Depth is exactly 2**ADDR_W.
//  - No X on outputs after the first reset edge. Register contents are undefined before reset.
// TESTING
//  1. rst=1 for 1 cycle, then read addresses 0..31 on both ports -> all rd_data=0, rd_busy=0.
//  2. Write reg5=0xDEADBEEF via port 0. Next cycle, read addr 5 on port 1 -> 0xDEADBEEF one cycle later.
//     Write 0x1234 to addr 0 -> reading addr 0 returns 0.
//  3. Bypass: in one cycle, wr_en=2'b01, addr7, 0xA5A5A5A5, with rd_addr port0=7 -> rd_data0=0xA5A5A5A5 after that edge.
//  4. Collision: both ports write addr 9, port0=0x1111, port1=0x2222. Same-cycle read returns 0x2222,
//     and the next read also returns 0x2222.
//  5. Scoreboard: set addr 3, then read 3 -> busy=1. Write 3 -> busy=0.
//     Set and write addr 3 in the same cycle -> busy=1. Set addr 0 -> busy stays 0.
//  6. Reset mid-stream: rst asserted in the same cycle as wr_en=2'b11 and sb_set_en=1 -> all state 0 after the edge,
//     and the write is not visible afterwards.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with registered reads, dual write ports, write-to-read bypass and busy scoreboard
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [1:0]               wr_en_i,
  input  logic [2*ADDR_W-1:0]      wr_addr_i,
  input  logic [2*DATA_W-1:0]      wr_data_i,
  input  logic                     sb_set_en_i,
  input  logic [ADDR_W-1:0]        sb_set_addr_i
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DATA_W-1:0]        regs_d [DEPTH];
  logic [DEPTH-1:0]         sb_q, sb_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
  logic [ADDR_W-1:0]        wa, ra;
  // Port 1 is applied after port 0 so it wins a collision; reads see the post-write array, which is the bypass.
  always_comb begin
    regs_d = regs_q;
    sb_d = sb_q;
    wa = '0;
    ra = '0;
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int j = 0; j < 2; j++) begin
      wa = wr_addr_i[j*ADDR_W +: ADDR_W];
      if (wr_en_i[j] && wa != '0) begin
        regs_d[wa] = wr_data_i[j*DATA_W +: DATA_W];
        sb_d[wa] = 1'b0;
      end
    end
    if (sb_set_en_i && sb_set_addr_i != '0) sb_d[sb_set_addr_i] = 1'b1;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr_i[i*ADDR_W +: ADDR_W];
      rd_data_d[i*DATA_W +: DATA_W] = ra == '0 ? '0 : regs_d[ra];
      rd_busy_d[i] = ra == '0 ? 1'b0 : sb_d[ra];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      sb_q <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= regs_d[k];
      sb_q <= sb_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end
  assign rd_data_o = rd_data_q;
  assign rd_busy_o = rd_busy_q;
endmodule
